// File: rtl/dm_access_stage.sv
// dm_access_stage
// ----------------------------------------------------------------------------
// Data-memory access stage between the EX/DM pipeline register and writeback.
// Decodes load/store controls, aligns byte lanes (little-endian), runs a
// single-outstanding req/ack data-memory access, stalls upstream while the
// access is pending, and registers the result into the DM/WB boundary.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_i .. ld_unsigned_i   EX/DM inputs (instruction, address/result,
//                         store data, rf write controls, load/store requests,
//                         access size, load extension mode)
//   stall_o               hold EX/DM and earlier stages
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o   data bus request
//   mem_ack_i, mem_rdata_i                                   data bus response
//   instr_o, wb_data_o, rf_we_o, rf_dst_addr_o               DM/WB register
//   misalign_o, bus_err_o one-cycle exception pulses
//   dbg_state_o           current FSM state (0 = IDLE, 1 = BUSY)
//
// Bus handshake: mem_req_o rises on the edge that enters BUSY and stays high,
// with address/byte-enables/write data/we held stable, until the edge that
// samples mem_ack_i=1 (transfer complete, mem_rdata_i valid in that same
// cycle) or the timeout expires. mem_ack_i is ignored whenever mem_req_o=0.
// ----------------------------------------------------------------------------

package dm_access_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } wrd_size_t;
endpackage

module dm_access_stage
  import dm_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_rslt_i,
  input  logic [31:0] p1_i,
  input  logic        rf_we_i,
  input  logic [4:0]  rf_dst_addr_i,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  input  wrd_size_t   word_size_i,
  input  logic        ld_unsigned_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] wb_data_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_dst_addr_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;
  logic [7:0] cnt_q;

  // Request decode (IDLE side)
  logic [1:0]  lane;
  logic        is_mem;
  logic        misaligned;
  logic        issue;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Access captured at issue; EX/DM is stalled but the copy keeps the bus
  // and the writeback fields independent of upstream behaviour.
  logic [31:0] addr_q, wdata_q, instr_q, alu_q;
  logic [3:0]  be_q;
  logic        we_q, rf_we_q, is_load_q, uns_q;
  logic [4:0]  dst_q;
  logic [1:0]  lane_q;
  wrd_size_t   size_q;

  // BUSY side
  logic        busy;
  logic        ack_done;
  logic        timeout_hit;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign lane   = alu_rslt_i[1:0];
  assign is_mem = dm_re_i | dm_we_i;

  always_comb begin
    be_c       = 4'b1111;
    wdata_c    = p1_i;
    misaligned = 1'b0;
    case (word_size_i)
      BYTE: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {24'b0, p1_i[7:0]} << {lane, 3'b000};
      end
      HALF: begin
        be_c       = 4'b0011 << lane;
        wdata_c    = {16'b0, p1_i[15:0]} << {lane, 3'b000};
        misaligned = is_mem & lane[0];
      end
      default: begin
        misaligned = is_mem & (lane != 2'b00);
      end
    endcase
  end

  assign issue       = is_mem & ~misaligned;
  assign busy        = (state_q == S_BUSY);
  assign ack_done    = busy & mem_ack_i;
  assign timeout_hit = busy & ~mem_ack_i & (cnt_q == TO_LAST);

  // FSM: next state and stall
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          stall_o = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Drop stall in the completing cycle so upstream advances on the
        // same edge that DM/WB captures the result.
        stall_o = ~mem_ack_i & ~timeout_hit;
        if (mem_ack_i || timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (busy && !mem_ack_i && !timeout_hit) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= 8'd0;
      end
    end
  end

  // Capture the access on the issue edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      we_q      <= 1'b0;
      instr_q   <= 32'd0;
      alu_q     <= 32'd0;
      rf_we_q   <= 1'b0;
      dst_q     <= 5'd0;
      is_load_q <= 1'b0;
      uns_q     <= 1'b0;
      lane_q    <= 2'd0;
      size_q    <= BYTE;
    end else if (state_q == S_IDLE && issue) begin
      addr_q    <= {alu_rslt_i[31:2], 2'b00};
      wdata_q   <= wdata_c;
      be_q      <= be_c;
      we_q      <= dm_we_i;
      instr_q   <= instr_i;
      alu_q     <= alu_rslt_i;
      // A simultaneous load+store request is treated as a store.
      rf_we_q   <= rf_we_i & ~dm_we_i;
      dst_q     <= rf_dst_addr_i;
      is_load_q <= ~dm_we_i;
      uns_q     <= ld_unsigned_i;
      lane_q    <= lane;
      size_q    <= word_size_i;
    end
  end

  // Bus outputs are only meaningful in BUSY; keep them quiet otherwise.
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = busy ? addr_q : 32'd0;
  assign mem_wdata_o = busy ? wdata_q : 32'd0;
  assign mem_be_o    = busy ? be_q : 4'd0;
  assign dbg_state_o = state_q;

  // Load data extraction and extension
  assign ld_shift = mem_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    ld_data = mem_rdata_i;
    case (size_q)
      BYTE:    ld_data = uns_q ? {24'b0, ld_shift[7:0]}
                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
      HALF:    ld_data = uns_q ? {16'b0, ld_shift[15:0]}
                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // DM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o       <= 32'd0;
      wb_data_o     <= 32'd0;
      rf_we_o       <= 1'b0;
      rf_dst_addr_o <= 5'd0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (state_q == S_IDLE && !issue) begin
        // Pass-through: non-memory op, or misaligned op squashed here.
        instr_o       <= instr_i;
        wb_data_o     <= alu_rslt_i;
        rf_we_o       <= rf_we_i & ~misaligned;
        rf_dst_addr_o <= rf_dst_addr_i;
        misalign_o    <= misaligned;
      end else if (ack_done) begin
        instr_o       <= instr_q;
        wb_data_o     <= is_load_q ? ld_data : alu_q;
        rf_we_o       <= rf_we_q;
        rf_dst_addr_o <= dst_q;
      end else begin
        // Issue cycle, wait cycles and timeout all insert a bubble.
        instr_o       <= 32'd0;
        wb_data_o     <= 32'd0;
        rf_we_o       <= 1'b0;
        rf_dst_addr_o <= 5'd0;
        bus_err_o     <= timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_stage.sv
// tb_dm_access_stage
// Bench for dm_access_stage with TIMEOUT_CYC = 4. A driver walks each access
// cycle by cycle acting as the memory, expected DM/WB results go into exp_q
// when an op is driven, and a negedge monitor pops them as non-bubble
// results appear at the DM/WB outputs.

module tb_dm_access_stage;
  import dm_access_pkg::*;

  localparam int T  = 4;
  localparam int EW = 70; // {instr[32], rf_we[1], dst[5], data[32]}

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_i, alu_rslt_i, p1_i;
  logic        rf_we_i;
  logic [4:0]  rf_dst_addr_i;
  logic        dm_re_i, dm_we_i;
  wrd_size_t   word_size_i;
  logic        ld_unsigned_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_o, wb_data_o;
  logic        rf_we_o;
  logic [4:0]  rf_dst_addr_o;
  logic        misalign_o, bus_err_o, dbg_state_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];

  dm_access_stage #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_i(instr_i), .alu_rslt_i(alu_rslt_i), .p1_i(p1_i),
    .rf_we_i(rf_we_i), .rf_dst_addr_i(rf_dst_addr_i),
    .dm_re_i(dm_re_i), .dm_we_i(dm_we_i),
    .word_size_i(word_size_i), .ld_unsigned_i(ld_unsigned_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .instr_o(instr_o), .wb_data_o(wb_data_o), .rf_we_o(rf_we_o),
    .rf_dst_addr_o(rf_dst_addr_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [EW-1:0] got,
                          input logic [EW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input wrd_size_t sz, input logic [1:0] a);
    case (sz)
      BYTE: case (a)
              2'd0: return 4'b0001;
              2'd1: return 4'b0010;
              2'd2: return 4'b0100;
              default: return 4'b1000;
            endcase
      HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input wrd_size_t sz, input logic [1:0] a,
                                          input logic [31:0] p1);
    logic [31:0] rep;
    logic [3:0]  be;
    logic [31:0] r;
    be = m_be(sz, a);
    if (sz == BYTE)      rep = {4{p1[7:0]}};
    else if (sz == HALF) rep = {2{p1[15:0]}};
    else                 rep = p1;
    r = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = rep[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input wrd_size_t sz, input logic [1:0] a,
                                         input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    if (sz == BYTE) return uns ? {24'd0, b} : 32'($signed(b));
    if (sz == HALF) return uns ? {16'd0, h} : 32'($signed(h));
    return rd;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && instr_o != 32'd0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_wb", {instr_o, rf_we_o, rf_dst_addr_o, wb_data_o}, '0);
      end else begin
        check_eq("wb", {instr_o, rf_we_o, rf_dst_addr_o, wb_data_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] instr, alu, p1, input logic rf_we,
                       input logic [4:0] dst, input logic re, we,
                       input wrd_size_t sz, input logic uns);
    instr_i = instr; alu_rslt_i = alu; p1_i = p1; rf_we_i = rf_we;
    rf_dst_addr_i = dst; dm_re_i = re; dm_we_i = we;
    word_size_i = sz; ld_unsigned_i = uns;
  endtask

  task automatic nop();
    drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, WORD, 1'b0);
  endtask

  // Non-memory op; optionally toggles a stray ack that must be ignored.
  task automatic alu_op(input logic [31:0] instr, alu, input logic rf_we,
                        input logic [4:0] dst, input logic stray_ack);
    drive(instr, alu, 32'd0, rf_we, dst, 1'b0, 1'b0, WORD, 1'b0);
    mem_ack_i = stray_ack; mem_rdata_i = $urandom;
    exp_q.push_back({instr, rf_we, dst, alu});
    @(negedge clk);
    check_eq("alu_stall", EW'(stall_o), EW'(0));
    check_eq("alu_req", EW'(mem_req_o), EW'(0));
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    check_eq("alu_state", EW'(dbg_state_o), EW'(0));
  endtask

  // Aligned memory op. delay >= T means the bus never acks.
  task automatic mem_op(input string tag, input logic [31:0] instr, addr, p1,
                        input logic rf_we, input logic [4:0] dst,
                        input logic re, we, input wrd_size_t sz, input logic uns,
                        input int delay, input logic [31:0] rdata);
    int stall_cnt, req_cnt, i;
    logic done;
    logic [31:0] exp_data;
    drive(instr, addr, p1, rf_we, dst, re, we, sz, uns);
    exp_data = we ? addr : m_load(sz, addr[1:0], uns, rdata);
    if (delay < T) exp_q.push_back({instr, rf_we & ~we, dst, exp_data});
    @(negedge clk);
    check_eq({tag, "_issue_stall"}, EW'(stall_o), EW'(1));
    check_eq({tag, "_issue_req"}, EW'(mem_req_o), EW'(0));
    stall_cnt = 1; req_cnt = 0; i = 0; done = 1'b0;
    @(posedge clk); #1;
    while (!done && i < T) begin
      if (i == delay) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
      end
      @(negedge clk);
      check_eq({tag, "_req"}, EW'(mem_req_o), EW'(1));
      check_eq({tag, "_bus"}, {mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o},
               EW'({addr[31:2], 2'b00, m_be(sz, addr[1:0]), we,
                    m_wdata(sz, addr[1:0], p1)}));
      if (mem_req_o) req_cnt++;
      if (stall_o) stall_cnt++;
      if (i == delay || i == T - 1) begin
        check_eq({tag, "_end_stall"}, EW'(stall_o), EW'(0));
        done = 1'b1;
      end
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      i++;
    end
    if (delay < T) begin
      check_eq({tag, "_stall_cycles"}, EW'(stall_cnt), EW'(delay + 1));
      check_eq({tag, "_bus_err"}, EW'(bus_err_o), EW'(0));
    end else begin
      check_eq({tag, "_req_cycles"}, EW'(req_cnt), EW'(T));
      check_eq({tag, "_bus_err"}, EW'(bus_err_o), EW'(1));
    end
    check_eq({tag, "_req_drop"}, EW'(mem_req_o), EW'(0));
    check_eq({tag, "_idle"}, EW'(dbg_state_o), EW'(0));
  endtask

  task automatic misaligned_op(input logic [31:0] instr, addr, input logic [4:0] dst,
                               input wrd_size_t sz);
    drive(instr, addr, 32'hCAFE_F00D, 1'b1, dst, 1'b1, 1'b0, sz, 1'b0);
    exp_q.push_back({instr, 1'b0, dst, addr});
    @(negedge clk);
    check_eq("mis_stall", EW'(stall_o), EW'(0));
    check_eq("mis_req", EW'(mem_req_o), EW'(0));
    @(posedge clk); #1;
    check_eq("mis_pulse", EW'(misalign_o), EW'(1));
    check_eq("mis_req_after", EW'(mem_req_o), EW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    nop();
    #1;
    check_eq("rst_async_outs",
             {stall_o, mem_req_o, rf_we_o, misalign_o, bus_err_o, dbg_state_o,
              instr_o, wb_data_o}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check_eq("rst_outs",
             {stall_o, mem_req_o, mem_we_o, mem_be_o, rf_we_o, rf_dst_addr_o,
              misalign_o, bus_err_o, dbg_state_o}, '0);
    check_eq("rst_wb", {instr_o, wb_data_o}, '0);
    @(posedge clk); #1;

    // Directed cases
    mem_op("lw", 32'h0000_2003, 32'h100, 32'd0, 1'b1, 5'd3, 1'b1, 1'b0, WORD, 1'b0,
           3, 32'hDEAD_BEEF);
    mem_op("lb", 32'h0000_0003, 32'h103, 32'd0, 1'b1, 5'd4, 1'b1, 1'b0, BYTE, 1'b0,
           0, 32'h80FF_0000);
    mem_op("lbu", 32'h0000_4003, 32'h103, 32'd0, 1'b1, 5'd5, 1'b1, 1'b0, BYTE, 1'b1,
           1, 32'h80FF_0000);
    mem_op("sh", 32'h0000_1023, 32'h202, 32'h1234_ABCD, 1'b1, 5'd6, 1'b0, 1'b1, HALF,
           1'b0, 0, 32'h0);
    mem_op("ldst", 32'h0000_2023, 32'h30C, 32'h5555_AAAA, 1'b1, 5'd7, 1'b1, 1'b1, WORD,
           1'b0, 2, 32'h1111_2222);
    misaligned_op(32'h0000_2083, 32'h101, 5'd8, WORD);
    alu_op(32'h0020_80B3, 32'h0000_0042, 1'b1, 5'd1, 1'b0);
    check_eq("mis_clear", EW'(misalign_o), EW'(0));
    misaligned_op(32'h0000_1083, 32'h203, 5'd9, HALF);
    alu_op(32'h0041_0133, 32'h1234_5678, 1'b1, 5'd2, 1'b1);
    mem_op("lh_s", 32'h0000_1103, 32'h402, 32'd0, 1'b1, 5'd10, 1'b1, 1'b0, HALF, 1'b0,
           0, 32'h9ABC_0123);

    // Randomised mix
    for (int n = 0; n < 24; n++) begin
      logic [31:0] base, ins;
      wrd_size_t   sz;
      logic [1:0]  ln;
      int          kind;
      base = $urandom & 32'hFFFF_FFFC;
      ins  = $urandom | 32'd1;
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0: begin sz = BYTE; ln = 2'($urandom_range(0, 3)); end
        1: begin sz = HALF; ln = {1'($urandom_range(0, 1)), 1'b0}; end
        default: begin sz = WORD; ln = 2'd0; end
      endcase
      if (kind == 0)
        alu_op(ins, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)));
      else
        mem_op("rnd", ins, base | 32'(ln), $urandom, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), kind == 1 ? 1'b0 : 1'b1,
               kind == 1 ? 1'b1 : 1'b0, sz, 1'($urandom_range(0, 1)),
               $urandom_range(0, T - 1), $urandom);
    end

    // Timeout: no ack ever
    mem_op("tmo", 32'h0000_2183, 32'h500, 32'd0, 1'b1, 5'd11, 1'b1, 1'b0, WORD, 1'b0,
           T, 32'h0);
    alu_op(32'h0000_0013, 32'h0000_0007, 1'b1, 5'd12, 1'b0);
    check_eq("bus_err_clear", EW'(bus_err_o), EW'(0));

    // Reset while BUSY
    drive(32'h0000_2203, 32'h600, 32'd0, 1'b1, 5'd13, 1'b1, 1'b0, WORD, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_busy_req", EW'(mem_req_o), EW'(1));
    rst_n = 1'b0;
    nop();
    #1;
    check_eq("rst_busy_outs",
             {stall_o, mem_req_o, mem_we_o, mem_be_o, rf_we_o, rf_dst_addr_o,
              misalign_o, bus_err_o, dbg_state_o}, '0);
    check_eq("rst_busy_wb", {instr_o, wb_data_o, mem_addr_o}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_req", EW'(mem_req_o), EW'(0));
    alu_op(32'h0000_0033, 32'h0000_00AA, 1'b1, 5'd14, 1'b0);
    nop();
    repeat (3) @(posedge clk);
    #1;
    check_eq("exp_q_empty", EW'(exp_q.size()), EW'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
